// File: rtl/masked_table_mem_mp.sv
// masked_table_mem_mp: shared masked S-box lookup table with N read
// channels, optional output register and a streaming run-time loader.
module masked_table_mem_mp #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 8,
  parameter int NUM_PORTS = 2,
  parameter int OUT_REG   = 1,
  parameter int PRELOADED = 0,
  parameter     INIT_FILE = "NONE"
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        ld_start,
  input  logic                        ld_valid,
  input  logic [DATA_W-1:0]           ld_data,
  output logic                        ld_ready,
  output logic                        load_done,
  output logic                        rd_ready,
  input  logic [NUM_PORTS-1:0]        rd_valid,
  input  logic [NUM_PORTS*ADDR_W-1:0] rd_addr,
  output logic [NUM_PORTS*DATA_W-1:0] dout,
  output logic [NUM_PORTS-1:0]        dout_valid
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NREP  = (NUM_PORTS + 1) / 2;

  typedef enum logic {S_LOAD, S_RUN} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              load_done_q;
  logic              run;
  logic              wr_en;

  assign run       = (state_q == S_RUN);
  assign ld_ready  = rst & en & ~run;
  assign rd_ready  = rst & en & run;
  assign load_done = load_done_q;
  assign wr_en     = ld_ready & ld_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= (PRELOADED != 0) ? S_RUN : S_LOAD;
      ptr_q       <= '0;
      load_done_q <= 1'b0;
    end else if (en) begin
      load_done_q <= 1'b0;
      unique case (state_q)
        S_LOAD: begin
          if (ld_valid) begin
            ptr_q <= ptr_q + 1'b1;
            if (&ptr_q) begin
              state_q     <= S_RUN;
              load_done_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (ld_start) begin
            ptr_q   <= '0;
            state_q <= S_LOAD;
          end
        end
      endcase
    end
  end

  // One table replica per port pair; the loader writes every replica.
  for (genvar r = 0; r < NREP; r++) begin : g_rep
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (wr_en) mem[ptr_q] <= ld_data;
    end

    for (genvar k = 0; k < 2; k++) begin : g_port
      if (2 * r + k < NUM_PORTS) begin : g_on
        localparam int P = 2 * r + k;

        logic [ADDR_W-1:0] addr;
        logic              acc;
        logic              v1_q;
        logic [DATA_W-1:0] d1_q;

        assign addr = rd_addr[P*ADDR_W +: ADDR_W];
        assign acc  = rd_ready & rd_valid[P];

        always_ff @(posedge clk or negedge rst) begin
          if (!rst) v1_q <= 1'b0;
          else if (en) v1_q <= acc;
        end

        if (OUT_REG != 0) begin : g_oreg
          logic              v2_q;
          logic [DATA_W-1:0] d2_q;

          always_ff @(posedge clk) begin
            if (en && acc) d1_q <= mem[addr];
          end

          always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
              v2_q <= 1'b0;
              d2_q <= '0;
            end else if (en) begin
              v2_q <= v1_q;
              if (v1_q) d2_q <= d1_q;
            end
          end

          assign dout[P*DATA_W +: DATA_W] = d2_q;
          assign dout_valid[P]            = v2_q;
        end else begin : g_noreg
          always_ff @(posedge clk or negedge rst) begin
            if (!rst) d1_q <= '0;
            else if (en && acc) d1_q <= mem[addr];
          end

          assign dout[P*DATA_W +: DATA_W] = d1_q;
          assign dout_valid[P]            = v1_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_masked_table_mem_mp.sv
// tb_masked_table_mem_mp: vector table plus scoreboard against two
// instances (OUT_REG=1 and OUT_REG=0) sharing all stimulus.
module tb_masked_table_mem_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        ld_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = '0;
  logic [1:0]  rd_valid = '0;
  logic [7:0]  rd_addr = '0;
  logic        ldr1, ldn1, rdr1, ldr0, ldn0, rdr0;
  logic [15:0] dout1, dout0;
  logic [1:0]  dv1, dv0;

  int   total = 0;
  int   bad = 0;
  int   ecnt = 0;
  logic en_edge = 1'b0;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  typedef struct {
    logic [1:0] v;
    logic [3:0] a0;
    logic [3:0] a1;
    logic [7:0] e0;
    logic [7:0] e1;
  } vec_t;

  // index 0/1: OUT_REG=1 ch0/ch1, index 2/3: OUT_REG=0 ch0/ch1
  exp_t sq[4][$];
  vec_t vt[7];

  masked_table_mem_mp #(
    .ADDR_W(4), .DATA_W(8), .NUM_PORTS(2), .OUT_REG(1), .PRELOADED(0)
  ) u1 (
    .clk(clk), .rst(rst), .en(en), .ld_start(ld_start),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ldr1),
    .load_done(ldn1), .rd_ready(rdr1), .rd_valid(rd_valid),
    .rd_addr(rd_addr), .dout(dout1), .dout_valid(dv1)
  );

  masked_table_mem_mp #(
    .ADDR_W(4), .DATA_W(8), .NUM_PORTS(2), .OUT_REG(0), .PRELOADED(0)
  ) u0 (
    .clk(clk), .rst(rst), .en(en), .ld_start(ld_start),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ldr0),
    .load_done(ldn0), .rd_ready(rdr0), .rd_valid(rd_valid),
    .rd_addr(rd_addr), .dout(dout0), .dout_valid(dv0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    en_edge = en;
    if (en && rst) ecnt++;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic push(int c, logic [7:0] d);
    exp_t e;
    e.data = d;
    e.due  = ecnt + 2;
    sq[c].push_back(e);
    e.due  = ecnt + 1;
    sq[2 + c].push_back(e);
  endtask

  always @(negedge clk) begin
    logic [3:0]  vall;
    logic [31:0] dall;
    logic [7:0]  d;
    exp_t        e;
    if (rst && en_edge) begin
      vall = {dv0, dv1};
      dall = {dout0, dout1};
      for (int i = 0; i < 4; i++) begin
        d = dall[i*8 +: 8];
        if (vall[i]) begin
          if (sq[i].size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_valid p%0d actual=%0h required=none",
                     i, d);
          end else begin
            e = sq[i].pop_front();
            chk($sformatf("data_p%0d", i), {24'd0, d}, {24'd0, e.data});
            chk($sformatf("due_p%0d", i), ecnt, e.due);
          end
        end else if (sq[i].size() != 0 && sq[i][0].due <= ecnt) begin
          e = sq[i].pop_front();
          total++;
          bad++;
          $display("FAIL missing_valid p%0d actual=none required=%0h",
                   i, e.data);
        end
      end
    end
  end

  task automatic load16(logic [7:0] base);
    for (int i = 0; i < 16; i++) begin
      ld_valid = 1'b1;
      ld_data  = base + 8'(i);
      if (i == 5) begin
        rd_valid = 2'b11;
        rd_addr  = 8'h34;
      end
      #1;
      chk("ld_ready", {30'd0, ldr1, ldr0}, 32'd3);
      chk("rd_ready_in_load", {30'd0, rdr1, rdr0}, 32'd0);
      if (i == 15) chk("load_done_early", {30'd0, ldn1, ldn0}, 32'd0);
      @(negedge clk);
      rd_valid = 2'b00;
    end
    ld_valid = 1'b0;
    chk("load_done", {30'd0, ldn1, ldn0}, 32'd3);
    chk("rd_ready_after", {30'd0, rdr1, rdr0}, 32'd3);
    @(negedge clk);
    chk("load_done_clr", {30'd0, ldn1, ldn0}, 32'd0);
  endtask

  initial begin
    vt[0] = '{v: 2'b11, a0: 4'd3, a1: 4'd15, e0: 8'hA3, e1: 8'hAF};
    vt[1] = '{v: 2'b01, a0: 4'd0, a1: 4'd0,  e0: 8'hA0, e1: 8'h00};
    vt[2] = '{v: 2'b01, a0: 4'd1, a1: 4'd0,  e0: 8'hA1, e1: 8'h00};
    vt[3] = '{v: 2'b01, a0: 4'd2, a1: 4'd0,  e0: 8'hA2, e1: 8'h00};
    vt[4] = '{v: 2'b11, a0: 4'd9, a1: 4'd9,  e0: 8'hA9, e1: 8'hA9};
    vt[5] = '{v: 2'b10, a0: 4'd0, a1: 4'd12, e0: 8'h00, e1: 8'hAC};
    vt[6] = '{v: 2'b11, a0: 4'd3, a1: 4'd15, e0: 8'hA3, e1: 8'hAF};

    en = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_dout", {dout1, dout0}, 32'd0);
    chk("rst_valid", {28'd0, dv1, dv0}, 32'd0);
    chk("rst_ld_ready", {30'd0, ldr1, ldr0}, 32'd0);
    chk("rst_load_done", {30'd0, ldn1, ldn0}, 32'd0);
    chk("rst_rd_ready", {30'd0, rdr1, rdr0}, 32'd0);
    rst = 1'b1;
    #1;
    chk("post_rst_ld_ready", {30'd0, ldr1, ldr0}, 32'd3);
    load16(8'hA0);

    for (int k = 0; k < 7; k++) begin
      rd_valid = vt[k].v;
      rd_addr  = {vt[k].a1, vt[k].a0};
      if (vt[k].v[0]) push(0, vt[k].e0);
      if (vt[k].v[1]) push(1, vt[k].e1);
      @(negedge clk);
    end
    rd_valid = 2'b00;
    repeat (3) @(negedge clk);
    chk("hold_dout1", {16'd0, dout1}, 32'hAFA3);
    chk("hold_dout0", {16'd0, dout0}, 32'hAFA3);
    chk("idle_valid", {28'd0, dv1, dv0}, 32'd0);

    rd_valid = 2'b01;
    rd_addr  = 8'h05;
    push(0, 8'hA5);
    @(negedge clk);
    en       = 1'b0;
    rd_valid = 2'b10;
    rd_addr  = 8'h10;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_rd_ready", {30'd0, rdr1, rdr0}, 32'd0);
      @(negedge clk);
      chk("stall_valid", {31'd0, dv1[0]}, 32'd0);
    end
    en       = 1'b1;
    rd_valid = 2'b00;
    @(negedge clk);
    chk("stall_rise", {31'd0, dv1[0]}, 32'd1);
    chk("stall_data", {24'd0, dout1[7:0]}, 32'hA5);
    repeat (2) @(negedge clk);

    rd_valid = 2'b01;
    rd_addr  = 8'h02;
    ld_start = 1'b1;
    ld_valid = 1'b1;
    ld_data  = 8'hEE;
    #1;
    chk("run_rd_ready", {30'd0, rdr1, rdr0}, 32'd3);
    push(0, 8'hA2);
    @(negedge clk);
    ld_start = 1'b0;
    ld_valid = 1'b0;
    rd_valid = 2'b00;
    #1;
    chk("reload_rd_ready", {30'd0, rdr1, rdr0}, 32'd0);
    chk("reload_ld_ready", {30'd0, ldr1, ldr0}, 32'd3);
    load16(8'h50);
    rd_valid = 2'b11;
    rd_addr  = {4'd0, 4'd2};
    push(0, 8'h52);
    push(1, 8'h50);
    @(negedge clk);
    rd_valid = 2'b00;
    repeat (3) @(negedge clk);

    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'h30 + 8'(i);
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    chk("arst_dout1", {16'd0, dout1}, 32'd0);
    chk("arst_dout0", {16'd0, dout0}, 32'd0);
    chk("arst_valid", {28'd0, dv1, dv0}, 32'd0);
    chk("arst_ld_ready", {30'd0, ldr1, ldr0}, 32'd0);
    chk("arst_flags", {28'd0, ldn1, ldn0, rdr1, rdr0}, 32'd0);
    ld_valid = 1'b0;
    for (int i = 0; i < 4; i++) sq[i].delete();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_ld_ready", {30'd0, ldr1, ldr0}, 32'd3);
    load16(8'h10);
    rd_valid = 2'b11;
    rd_addr  = {4'd7, 4'd0};
    push(0, 8'h10);
    push(1, 8'h17);
    @(negedge clk);
    rd_valid = 2'b01;
    rd_addr  = 8'h0F;
    push(0, 8'h1F);
    @(negedge clk);
    rd_valid = 2'b00;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 4; i++)
      chk($sformatf("drain_p%0d", i), sq[i].size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
